versat_databus_arbiter: RTL and testbench



---
 rtl/versat_databus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_versat_databus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/versat_databus_arbiter.sv
// Round-robin, burst-granular arbiter sharing one Versat databus master port
// between N_SLAVES requesters; the grant is held from arbitration until the last beat.
module versat_databus_arbiter #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 20
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             cke_i,
  input  logic [N_SLAVES-1:0]              s_valid_i,
  output logic [N_SLAVES-1:0]              s_ready_o,
  output logic [N_SLAVES-1:0]              s_last_o,
  input  logic [N_SLAVES*ADDR_W-1:0]       s_addr_i,
  input  logic [N_SLAVES*DATA_W-1:0]       s_wdata_i,
  input  logic [N_SLAVES*(DATA_W/8)-1:0]   s_wstrb_i,
  input  logic [N_SLAVES*LEN_W-1:0]        s_len_i,
  output logic [DATA_W-1:0]                s_rdata_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  input  logic                             m_last_i,
  output logic                             m_write_o,
  output logic [ADDR_W-1:0]                m_addr_o,
  output logic [LEN_W-1:0]                 m_len_o,
  output logic [DATA_W-1:0]                m_wdata_o,
  output logic [DATA_W/8-1:0]              m_wstrb_o,
  input  logic [DATA_W-1:0]                m_rdata_i,
  output logic [N_SLAVES-1:0]              grant_o,
  output logic                             busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  // Handshake: a beat transfers on the rising edge where m_valid_o & m_ready_i
  // are both high in BURST; s_ready_o[g] is m_ready_i passed straight through,
  // and the burst ends on the transferring beat that also carries m_last_i.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_BURST   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [N_SLAVES-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  write_q, write_d;

  logic [ADDR_W-1:0]     addr_a  [N_SLAVES];
  logic [DATA_W-1:0]     wdata_a [N_SLAVES];
  logic [STRB_W-1:0]     wstrb_a [N_SLAVES];
  logic [LEN_W-1:0]      len_a   [N_SLAVES];

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand;
  logic                  in_burst;
  logic                  beat_valid;
  logic                  burst_done;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_SLAVES - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < N_SLAVES; k++) begin
      addr_a[k]  = s_addr_i[k*ADDR_W +: ADDR_W];
      wdata_a[k] = s_wdata_i[k*DATA_W +: DATA_W];
      wstrb_a[k] = s_wstrb_i[k*STRB_W +: STRB_W];
      len_a[k]   = s_len_i[k*LEN_W +: LEN_W];
    end
  end

  // Rotating priority: first valid requester at or above ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!win_found && s_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign in_burst   = (state_q == ST_BURST);
  assign beat_valid = in_burst & s_valid_i[gidx_q];
  assign burst_done = beat_valid & m_ready_i & m_last_i;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    len_d     = len_q;
    write_d   = write_q;
    m_valid_o = 1'b0;
    s_ready_o = '0;
    s_last_o  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d           = win_idx;
          addr_d           = addr_a[win_idx];
          len_d            = len_a[win_idx];
          write_d          = |wstrb_a[win_idx];
          state_d          = ST_ARB;
        end
      end
      ST_ARB: begin
        state_d = ST_BURST;
      end
      ST_BURST: begin
        m_valid_o = beat_valid;
        s_ready_o = grant_q & {N_SLAVES{m_ready_i}};
        s_last_o  = grant_q & {N_SLAVES{m_last_i}};
        if (burst_done) begin
          grant_d = '0;
          ptr_d   = next_idx(gidx_q);
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      write_q <= write_d;
    end
  end

  // Write payload only reflects the granted slice while beats can flow.
  assign m_wdata_o = in_burst ? wdata_a[gidx_q] : '0;
  assign m_wstrb_o = in_burst ? wstrb_a[gidx_q] : '0;
  assign m_addr_o  = addr_q;
  assign m_len_o   = len_q;
  assign m_write_o = write_q;
  assign s_rdata_o = m_rdata_i;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != ST_IDLE);

  grant_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(grant_q));
  grant_state_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ((grant_q != '0) == ((state_q == ST_ARB) || (state_q == ST_BURST))));

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// Directed bench for versat_databus_arbiter: stimulus pushes expected beats and
// grants into queues; negedge monitors pop and compare when the DUT presents them.
module tb_versat_databus_arbiter;

  localparam int N      = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LW     = 20;
  localparam int SW     = DW / 8;
  localparam int BEAT_W = 3*N + 1 + AW + LW + DW + SW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n_i = 1'b0;
  logic            cke_i   = 1'b1;
  logic [N-1:0]    s_valid_i = '0;
  logic [N-1:0]    s_ready_o, s_last_o;
  logic [N*AW-1:0] s_addr_i  = '0;
  logic [N*DW-1:0] s_wdata_i = '0;
  logic [N*SW-1:0] s_wstrb_i = '0;
  logic [N*LW-1:0] s_len_i   = '0;
  logic [DW-1:0]   s_rdata_o;
  logic            m_valid_o;
  logic            m_ready_i = 1'b0;
  logic            m_last_i  = 1'b0;
  logic            m_write_o;
  logic [AW-1:0]   m_addr_o;
  logic [LW-1:0]   m_len_o;
  logic [DW-1:0]   m_wdata_o;
  logic [SW-1:0]   m_wstrb_o;
  logic [DW-1:0]   m_rdata_i = '0;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  versat_databus_arbiter #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .cke_i(cke_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_o(s_last_o),
    .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_len_i(s_len_i), .s_rdata_o(s_rdata_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_i(m_last_i),
    .m_write_o(m_write_o), .m_addr_o(m_addr_o), .m_len_o(m_len_o),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_rdata_i(m_rdata_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // ---------------- scoreboard state ----------------
  logic [BEAT_W-1:0] exp_q[$];
  logic [N-1:0]      exp_g[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beat_cnt = 0;
  logic [AW-1:0] lat_addr [N];
  logic [LW-1:0] lat_len  [N];
  logic          lat_write[N];
  logic [SW-1:0] drv_strb [N];
  logic [BEAT_W-1:0] mon_act, mon_exp;
  logic [N-1:0]      prev_g = '0;

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int j, input int cnt);
    return DW'((j + 1) << 28) + DW'(cnt);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n_i && cke_i && m_valid_o && m_ready_i) begin
      mon_act = {grant_o, s_ready_o, s_last_o, m_write_o, m_addr_o, m_len_o, m_wdata_o, m_wstrb_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL beat: got %0h expected %0h", mon_act, mon_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (grant_o != '0 && grant_o !== prev_g) begin
      n_cmp++;
      if (exp_g.size() == 0) begin
        n_bad++;
        $display("FAIL grant_unexpected: got %b expected none", grant_o);
      end else if (grant_o !== exp_g[0]) begin
        n_bad++;
        $display("FAIL grant_order: got %b expected %b", grant_o, exp_g[0]);
        void'(exp_g.pop_front());
      end else begin
        void'(exp_g.pop_front());
      end
    end
    prev_g <= grant_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int r, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input logic [SW-1:0] strb);
    s_addr_i[r*AW +: AW]  = addr;
    s_len_i[r*LW +: LW]   = len;
    s_wstrb_i[r*SW +: SW] = strb;
    lat_addr[r]  = addr;
    lat_len[r]   = len;
    lat_write[r] = |strb;
    drv_strb[r]  = strb;
  endtask

  task automatic wait_grant(input int r, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (grant_o === oh(r)) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL grant_wait: got %b expected %b", grant_o, oh(r));
    end
  endtask

  // One cycle of a burst seen from requester r and the downstream bridge.
  task automatic beat(input int r, input logic vld, input logic rdy, input logic lst);
    s_valid_i[r] = vld;
    m_ready_i    = rdy;
    m_last_i     = lst;
    s_wstrb_i[r*SW +: SW] = drv_strb[r];
    for (int j = 0; j < N; j++) s_wdata_i[j*DW +: DW] = wdata_of(j, beat_cnt);
    if (vld && rdy)
      exp_q.push_back({oh(r), oh(r), lst ? oh(r) : {N{1'b0}}, lat_write[r], lat_addr[r],
                       lat_len[r], wdata_of(r, beat_cnt), drv_strb[r]});
    beat_cnt++;
    @(negedge clk);
    check("beat_m_valid", m_valid_o, vld);
    check("beat_s_ready", s_ready_o, rdy ? oh(r) : {N{1'b0}});
    check("beat_s_last", s_last_o, lst ? oh(r) : {N{1'b0}});
    check("beat_grant_held", grant_o, oh(r));
    check("beat_addr_held", m_addr_o, lat_addr[r]);
    tick();
  endtask

  // Called at the negedge of ARB; returns just after the last-beat edge.
  task automatic burst(input int r, input int nbeats, input bit keep);
    tick();
    for (int k = 0; k < nbeats; k++) beat(r, 1'b1, 1'b1, k == nbeats - 1);
    m_ready_i = 1'b0;
    m_last_i  = 1'b0;
    if (!keep) s_valid_i[r] = 1'b0;
  endtask

  // RELEASE then IDLE after the final beat; ends at the IDLE negedge.
  task automatic check_gap(input int r);
    @(negedge clk);
    check("rel_grant", grant_o, 0);
    check("rel_busy", busy_o, 1);
    check("rel_ready", s_ready_o, 0);
    check("rel_addr", m_addr_o, lat_addr[r]);
    @(negedge clk);
    check("idle_busy", busy_o, 0);
    check("idle_grant", grant_o, 0);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int lat;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_addr", m_addr_o, 0);
    check("rst_len", m_len_o, 0);
    check("rst_write", m_write_o, 0);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_s_ready", s_ready_o, 0);
    check("rst_s_last", s_last_o, 0);
    tick();
    rst_n_i = 1'b1;

    // Single requester 2, 4-beat write; valid driven after an edge, so the
    // grant shows at the second negedge (one cycle later).
    setup(2, 32'h0000_1000, 20'd16, 4'hF);
    exp_g.push_back(4'b0100);
    s_valid_i[2] = 1'b1;
    wait_grant(2, lat);
    check("t1_grant_latency", lat, 2);
    check("t1_write", m_write_o, 1);
    check("t1_addr", m_addr_o, 32'h0000_1000);
    check("t1_len", m_len_o, 16);
    check("t1_arb_busy", busy_o, 1);
    check("t1_arb_no_valid", m_valid_o, 0);
    burst(2, 4, 1'b0);
    check_gap(2);

    // ptr is now 3: req 3 beats req 0, then wraps to req 0.
    setup(3, 32'h0000_3300, 20'd4, 4'h0);
    setup(0, 32'h0000_0500, 20'd8, 4'h3);
    exp_g.push_back(4'b1000);
    exp_g.push_back(4'b0001);
    s_valid_i[3] = 1'b1;
    s_valid_i[0] = 1'b1;
    wait_grant(3, lat);
    check("t2_read", m_write_o, 0);
    burst(3, 1, 1'b0);
    check_gap(3);
    wait_grant(0, lat);
    check("t2_wrap_latency", lat, 1);
    burst(0, 2, 1'b0);
    check_gap(0);

    // Round robin with every requester holding valid
    do_reset();
    for (int j = 0; j < N; j++) setup(j, AW'(32'h100 * (j + 1)), 20'd8, 4'hF);
    for (int i = 0; i < 5; i++) exp_g.push_back(oh(i % N));
    s_valid_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(i % N, lat);
      if (i > 0) check("rr_turnaround", lat, 1);
      burst(i % N, 2, i < 4);
      if (i == 4) s_valid_i = '0;
      check_gap(i % N);
    end

    // Hold under address change and dropped valid (req 1 read)
    setup(1, 32'h0000_2000, 20'd8, 4'h0);
    exp_g.push_back(4'b0010);
    s_valid_i[1] = 1'b1;
    wait_grant(1, lat);
    tick();
    beat(1, 1'b1, 1'b1, 1'b0);
    s_addr_i[1*AW +: AW] = 32'hDEAD_0000;
    m_rdata_i = 32'h5A5A_1234;
    repeat (3) beat(1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_rdata", s_rdata_o, 32'h5A5A_1234);
    check("t4_busy", busy_o, 1);
    tick();
    beat(1, 1'b1, 1'b1, 1'b1);
    m_ready_i = 1'b0;
    m_last_i  = 1'b0;
    s_valid_i[1] = 1'b0;
    check_gap(1);

    // Ready stalls, last without handshake, zero-strobe beat in a write burst
    setup(2, 32'h0000_3000, 20'd12, 4'hF);
    exp_g.push_back(4'b0100);
    s_valid_i[2] = 1'b1;
    wait_grant(2, lat);
    tick();
    beat(2, 1'b1, 1'b1, 1'b0);
    beat(2, 1'b1, 1'b0, 1'b0);
    beat(2, 1'b1, 1'b0, 1'b1);
    drv_strb[2] = 4'h0;
    beat(2, 1'b1, 1'b1, 1'b0);
    drv_strb[2] = 4'hF;
    beat(2, 1'b0, 1'b1, 1'b1);
    beat(2, 1'b1, 1'b1, 1'b1);
    m_ready_i = 1'b0;
    m_last_i  = 1'b0;
    s_valid_i[2] = 1'b0;
    check_gap(2);

    // Reset during beat 2 of req 3; afterwards ptr restarts at 0
    setup(3, 32'h0000_6000, 20'd8, 4'hF);
    setup(0, 32'h0000_0700, 20'd4, 4'h0);
    exp_g.push_back(4'b1000);
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b1000);
    s_valid_i[3] = 1'b1;
    wait_grant(3, lat);
    tick();
    beat(3, 1'b1, 1'b1, 1'b0);
    m_ready_i = 1'b1;
    rst_n_i   = 1'b0;
    tick();
    rst_n_i   = 1'b1;
    m_ready_i = 1'b0;
    s_valid_i = 4'b1001;
    @(negedge clk);
    check("t6_grant", grant_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_m_valid", m_valid_o, 0);
    check("t6_addr", m_addr_o, 0);
    wait_grant(0, lat);
    burst(0, 1, 1'b0);
    check_gap(0);
    wait_grant(3, lat);
    burst(3, 1, 1'b0);
    check_gap(3);

    // Clock enable low for 5 cycles mid-burst with a pending last handshake
    setup(1, 32'h0000_4000, 20'd20, 4'hF);
    exp_g.push_back(4'b0010);
    s_valid_i[1] = 1'b1;
    wait_grant(1, lat);
    tick();
    beat(1, 1'b1, 1'b1, 1'b0);
    cke_i = 1'b0;
    s_addr_i[1*AW +: AW] = 32'hBEEF_0000;
    m_ready_i = 1'b1;
    m_last_i  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("cke_grant", grant_o, 4'b0010);
      check("cke_busy", busy_o, 1);
      check("cke_addr", m_addr_o, 32'h0000_4000);
      check("cke_s_ready", s_ready_o, 4'b0010);
      tick();
    end
    cke_i = 1'b1;
    beat(1, 1'b1, 1'b1, 1'b1);
    m_ready_i = 1'b0;
    m_last_i  = 1'b0;
    s_valid_i[1] = 1'b0;
    check_gap(1);

    // Final report
    repeat (3) tick();
    check("beats_outstanding", exp_q.size(), 0);
    check("grants_outstanding", exp_g.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
